// File: rtl/i2c_write_engine.sv
// Bit-level I2C master that sends one 3-byte write (slave address, sub-address, data).
// The FSM advances only on an internal quarter-bit clock-enable derived from iCLK.
module i2c_write_engine #(
  parameter int unsigned CLK_Freq = 50000000,
  parameter int unsigned I2C_Freq = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  // DIV must lie in 2..65535 for the 16-bit divider to hit its terminal count.
  localparam int unsigned Div     = CLK_Freq / (4 * I2C_Freq);
  localparam logic [15:0] DivLast = 16'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBit,
    StStop,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [4:0]  slot_q, slot_d;
  logic [23:0] shift_q, shift_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        end_q, end_d;
  logic        sda_meta_q, sda_sync_q;
  logic        tick;
  logic        is_ack;

  assign tick   = (div_q == DivLast);
  assign div_d  = tick ? 16'd0 : div_q + 16'd1;
  assign is_ack = (slot_q == 5'd8) || (slot_q == 5'd17) || (slot_q == 5'd26);

  assign I2C_SCLK = scl_q;
  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign oEND     = end_q;
  assign oACK     = ack_err_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_q <= 16'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // SDA comes from an external open-drain bus; resynchronise before sampling the ack.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= I2C_SDAT;
      sda_sync_q <= sda_meta_q;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= StIdle;
      qtr_q     <= 2'd0;
      slot_q    <= 5'd0;
      shift_q   <= 24'd0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      slot_q    <= slot_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      end_q     <= end_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    slot_d    = slot_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    end_d     = end_q;

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          scl_d    = 1'b1;
          sda_oe_d = 1'b0;
          end_d    = 1'b0;
          if (iGO) begin
            shift_d   = iDATA;
            ack_err_d = 1'b0;
            qtr_d     = 2'd0;
            state_d   = StStart;
          end
        end

        StStart: begin
          qtr_d = qtr_q + 2'd1;
          unique case (qtr_q)
            2'd0: begin
              scl_d    = 1'b1;
              sda_oe_d = 1'b0;
            end
            2'd1: sda_oe_d = 1'b1;
            2'd2: ;
            2'd3: begin
              scl_d   = 1'b0;
              slot_d  = 5'd0;
              state_d = StBit;
            end
            default: ;
          endcase
        end

        StBit: begin
          qtr_d = qtr_q + 2'd1;
          unique case (qtr_q)
            2'd0: sda_oe_d = is_ack ? 1'b0 : ~shift_q[23];
            2'd1: scl_d = 1'b1;
            2'd2: begin
              // Sticky: any NACK among the three ack slots is reported.
              if (is_ack && sda_sync_q) begin
                ack_err_d = 1'b1;
              end
            end
            2'd3: begin
              scl_d = 1'b0;
              if (!is_ack) begin
                shift_d = {shift_q[22:0], 1'b0};
              end
              if (slot_q == 5'd26) begin
                state_d = StStop;
              end else begin
                slot_d = slot_q + 5'd1;
              end
            end
            default: ;
          endcase
        end

        StStop: begin
          qtr_d = qtr_q + 2'd1;
          unique case (qtr_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_d = 1'b1;
            2'd2: sda_oe_d = 1'b0;
            2'd3: begin
              end_d   = 1'b1;
              state_d = StDone;
            end
            default: ;
          endcase
        end

        StDone: begin
          if (!iGO) begin
            end_d   = 1'b0;
            state_d = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine: a passive bus monitor plus an acking slave model
// check framing, bit order, ack handling, handshake, reset and divider timing.
module tb_i2c_write_engine;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND, oACK, I2C_SCLK;
  wire         sda_bus;
  logic        sda_drv = 1'b0;
  wire         sda_lvl;

  logic        go2;
  logic        end2, ack2, scl2;
  wire         sda2_bus;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  // Monitor / slave state
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;
  logic        in_xfer = 1'b0;
  int          pc = 0;
  int          pc_stop = 0;
  int unsigned n_start = 0;
  int unsigned n_stop = 0;
  logic [26:0] bits = '0;
  logic [2:0]  nack_cfg = 3'b000;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  pullup pu1 (sda_bus);
  pullup pu2 (sda2_bus);
  assign sda_bus = sda_drv ? 1'b0 : 1'bz;
  assign sda_lvl = (sda_bus === 1'b0) ? 1'b0 : 1'b1;

  i2c_write_engine #(
    .CLK_Freq(320000),
    .I2C_Freq(20000)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iGO     (iGO),
    .oEND    (oEND),
    .oACK    (oACK),
    .I2C_SCLK(I2C_SCLK),
    .I2C_SDAT(sda_bus)
  );

  i2c_write_engine #(
    .CLK_Freq(50000000),
    .I2C_Freq(20000)
  ) dut_div (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (24'h341201),
    .iGO     (go2),
    .oEND    (end2),
    .oACK    (ack2),
    .I2C_SCLK(scl2),
    .I2C_SDAT(sda2_bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pc = slot index in progress (-1 between START and the first SCL fall).
  always @(sda_lvl or I2C_SCLK) begin
    if (scl_p && I2C_SCLK && sda_p && !sda_lvl) begin
      n_start++;
      pc      = -1;
      in_xfer = 1'b1;
    end else if (scl_p && I2C_SCLK && !sda_p && sda_lvl) begin
      if (in_xfer) begin
        n_stop++;
        pc_stop = pc;
      end
      in_xfer = 1'b0;
    end else if (!scl_p && I2C_SCLK) begin
      if (in_xfer && pc >= 0 && pc < 27) bits[26-pc] = sda_lvl;
    end else if (scl_p && !I2C_SCLK && in_xfer) begin
      pc++;
      sda_drv = (pc == 8 && !nack_cfg[2]) || (pc == 17 && !nack_cfg[1]) ||
                (pc == 26 && !nack_cfg[0]);
    end
    scl_p = I2C_SCLK;
    sda_p = sda_lvl;
  end

  // Runs one transfer and leaves iGO high with oEND expected high.
  task automatic run_xfer(input string tag, input logic [23:0] data, input logic [2:0] nack,
                          input logic exp_ack, input int chg_slot);
    int unsigned c0, c_fall, n_start0, n_stop0;
    bit          fell;
    nack_cfg = nack;
    n_start0 = n_start;
    n_stop0  = n_stop;
    @(negedge iCLK);
    iDATA = data;
    iGO   = 1'b1;
    c0    = cyc;
    fell  = 1'b0;
    c_fall = 0;
    for (int i = 0; i < 1000 && !oEND; i++) begin
      @(negedge iCLK);
      if (!fell && !I2C_SCLK) begin
        fell   = 1'b1;
        c_fall = cyc;
      end
      if (chg_slot >= 0 && n_start != n_start0 && pc == chg_slot) iDATA = 24'hFFFFFF;
    end
    check_eq({tag, " end_seen"}, 32'(oEND), 32'd1);
    check_eq({tag, " data"}, 32'({bits[26:19], bits[17:10], bits[8:1]}), 32'(data));
    check_eq({tag, " ack_bits"}, 32'({bits[18], bits[9], bits[0]}), 32'(nack));
    check_eq({tag, " starts"}, n_start - n_start0, 32'd1);
    check_eq({tag, " stops"}, n_stop - n_stop0, 32'd1);
    check_eq({tag, " pulses"}, 32'(pc_stop), 32'd27);
    check_eq({tag, " fall_to_end"}, cyc - c_fall, 32'd448);
    check_eq({tag, " go_to_end_win"}, 32'((cyc - c0 >= 465) && (cyc - c0 <= 468)), 32'd1);
    check_eq({tag, " oack"}, 32'(oACK), 32'(exp_ack));
    iDATA = 24'h000000;
  endtask

  task automatic release_go(input string tag);
    int unsigned c0;
    @(negedge iCLK);
    iGO = 1'b0;
    c0  = cyc;
    for (int i = 0; i < 8 && oEND; i++) @(negedge iCLK);
    check_eq({tag, " end_fall_win"}, 32'(!oEND && (cyc - c0 >= 1) && (cyc - c0 <= 4)), 32'd1);
  endtask

  initial begin
    int unsigned ns0, c1, c2;
    iRST  = 1'b1;
    iGO   = 1'b0;
    go2   = 1'b0;
    iDATA = 24'h000000;
    repeat (3) @(negedge iCLK);
    check_eq("rst scl", 32'(I2C_SCLK), 32'd1);
    check_eq("rst sda", 32'(sda_bus !== 1'b0), 32'd1);
    check_eq("rst end", 32'(oEND), 32'd0);
    check_eq("rst ack", 32'(oACK), 32'd0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);

    run_xfer("t1", 24'h341201, 3'b000, 1'b0, -1);
    release_go("t1");
    run_xfer("t2_nack", 24'h341201, 3'b010, 1'b1, -1);
    release_go("t2");
    run_xfer("t3", 24'hA07F80, 3'b000, 1'b0, -1);

    // Hold iGO 10 ticks past oEND: no new START, oEND stays high.
    ns0 = n_start;
    repeat (40) @(negedge iCLK);
    check_eq("hold end", 32'(oEND), 32'd1);
    check_eq("hold no_start", n_start - ns0, 32'd0);
    check_eq("hold scl", 32'(I2C_SCLK), 32'd1);
    release_go("t3");

    run_xfer("t4_chg", 24'h341201, 3'b000, 1'b0, 5);
    release_go("t4");

    // Asynchronous reset at slot 12.
    ns0 = n_start;
    @(negedge iCLK);
    iDATA = 24'h341201;
    iGO   = 1'b1;
    for (int i = 0; i < 1000 && !(n_start != ns0 && pc == 12); i++) @(negedge iCLK);
    check_eq("rst12 reached", 32'(pc), 32'd12);
    #1;
    iRST = 1'b1;
    #1;
    check_eq("rst12 scl", 32'(I2C_SCLK), 32'd1);
    check_eq("rst12 sda", 32'(sda_bus !== 1'b0), 32'd1);
    check_eq("rst12 end", 32'(oEND), 32'd0);
    @(negedge iCLK);
    iGO = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    repeat (4) @(negedge iCLK);
    run_xfer("t5_post", 24'h5AC30F, 3'b001, 1'b1, -1);
    release_go("t5");

    // Divider at default parameters: SCL period must be 4*625 cycles.
    @(negedge iCLK);
    go2 = 1'b1;
    for (int i = 0; i < 10000 && scl2; i++) @(negedge iCLK);
    for (int i = 0; i < 5000 && !scl2; i++) @(negedge iCLK);
    c1 = cyc;
    for (int i = 0; i < 5000 && scl2; i++) @(negedge iCLK);
    for (int i = 0; i < 5000 && !scl2; i++) @(negedge iCLK);
    c2 = cyc;
    check_eq("div scl_period", c2 - c1, 32'd2500);
    go2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_write_engine.md
# i2c_write_engine

Bit-level I2C master that executes one 3-byte write transaction: slave address, sub-address, data. It sits directly downstream of the AV codec/video-decoder configuration sequencer. The sequencer presents a 24-bit word with a level GO; this block serialises it onto I2C_SCLK/I2C_SDAT and returns END plus an acknowledge-error flag. It runs on the system clock with an internal quarter-bit clock-enable, so no derived clock crosses into the sequencer.

## Interface
Parameters:
- CLK_Freq, 50000000 — system clock frequency in Hz.
- I2C_Freq, 20000 — SCL frequency in Hz.
- Constraint: DIV = CLK_Freq/(4*I2C_Freq), integer division, must satisfy 2 ≤ DIV ≤ 65535.

Ports (one clock; reset is asynchronous and active-high):
- iCLK, input, 1 — system clock.
- iRST, input, 1 — asynchronous, active-high reset.
- iDATA, input, 24 — {slave addr incl. R/W=0, sub-addr, data}; sent MSB first.
- iGO, input, 1 — level request; hold high until oEND.
- oEND, output, 1 — transaction complete; held until iGO is seen low.
- oACK, output, 1 — 1 = at least one of the 3 ack slots was NACKed; valid while oEND=1.
- I2C_SCLK, output, 1 — push-pull SCL.
- I2C_SDAT, inout, 1 — open-drain SDA: driven 0 or released (Z), never driven 1.

## Operation
- Tick generator: a 16-bit counter counts 0..DIV-1 and emits a one-cycle `tick` at DIV-1, then wraps to 0. It free-runs out of reset. The FSM updates only on tick cycles.
- Every phase is 4 ticks, q0..q3. A 2-bit quarter counter and a 5-bit slot counter (0..26) track position.
- IDLE: SCL=1, SDA released, oEND=0. On a tick with iGO=1:
  - latch iDATA into a shift register;
  - clear the ack-error flag;
  - go to START.
- START: q0 SCL=1, SDA released; q1 SDA=0; q2 hold; q3 SCL=0 → BIT, slot 0.
- BIT, 27 slots: slots 8, 17 and 26 are ack slots; all others are data bits.
  - q0: for a data bit, drive SDA=0 if the bit is 0, release if 1; for an ack slot, release SDA.
  - q1: SCL=1.
  - q2: in an ack slot, sample SDA; a 1 sets the sticky ack-error flag.
  - q3: SCL=0; after slot 26 → STOP.
- A NACK does not abort: all 27 slots and STOP always execute.
- STOP: q0 SDA=0; q1 SCL=1; q2 SDA released; q3 hold → DONE.
- DONE: oEND=1, oACK=flag. On a tick with iGO=0 → IDLE, oEND=0. While iGO stays 1, remain in DONE; a new transfer needs iGO low for at least one tick.
- iDATA and iGO changes during START/BIT/STOP are ignored.

## Timing
- Reset values: I2C_SCLK=1, I2C_SDAT=Z, oEND=0, oACK=0, FSM=IDLE, divider=0.
- Reset asserted mid-transfer: outputs return to their reset values immediately (asynchronous). No STOP is generated; bus recovery is the caller's responsibility.
- Latency: START(4) + 27×4 + STOP(4) = 116 ticks.
  - oEND rises on the 116th tick after the tick that sampled iGO=1.
  - Total is 117 ticks ≈ 117×DIV iCLK cycles from iGO to oEND.
- oEND falls on the first tick with iGO=0 while in DONE. Minimum oEND width is 1 tick (DIV cycles).
- SDA changes only in q0 (data), START q1, or STOP q0/q2, always while SCL is stable. SCL high time and low time are each 2 ticks.
- oACK is stable for the whole oEND-high interval and is updated only at ack-slot q2 samples.
- All outputs are registered; SDA output-enable is registered as well.

## Test plan
- Single write, slave model ACKs all bytes, DIV=4, iDATA=0x341201:
  - SCL shows 27 clock pulses;
  - SDA bits read 0011_0100, 0001_0010, 0000_0001, with START and STOP framing;
  - oEND rises 117 ticks after iGO; oACK=0.
- Slave NACKs byte 2 only: remaining bits and STOP still emitted; oACK=1 at oEND; next transfer with full ACK returns oACK=0.
- Handshake:
  - iGO held high 10 ticks past oEND → oEND stays high, no new START;
  - iGO dropped → oEND low on the next tick;
  - iGO reasserted → new START.
- iDATA changed to 0xFFFFFF during slot 5: transmitted bits still match the originally latched 0x341201.
- iRST pulsed at slot 12: SCL=1 and SDA=Z in the same cycle, oEND=0; after release, a normal transfer completes correctly.
- Divider check with CLK_Freq=50000000, I2C_Freq=20000: DIV=625; measured SCL period is 2500 iCLK cycles.
